// File: rtl/ula_sequencer.sv
// Multi-cycle control FSM for the ULA datapath: fetch, decode, register read, execute, writeback.
// Every output is a flop loaded from its next-cycle value, so strobes line up with the state they belong to.
module ula_sequencer #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned PROG_LEN = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_en,
    input  logic [15:0]     imem_data,
    output logic            rf_rd,
    output logic            rf_wr,
    output logic [3:0]      rf_wr_addr,
    output logic [3:0]      rf_rd_addr_a,
    output logic [3:0]      rf_rd_addr_b,
    output logic [3:0]      alu_op,
    output logic            alu_use_imm,
    output logic [3:0]      alu_imm,
    output logic            alu_latch,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [15:0]     instr_count
);

    localparam int unsigned CNT_W  = 16;
    localparam logic [3:0]  OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    function automatic logic is_imm(input logic [3:0] op);
        return (op == 4'h3) || (op >= 4'h6 && op <= 4'hA);
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        return op <= 4'hA;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halted_q, halted_d, illegal_q, illegal_d;
    logic               imem_en_d, rf_rd_d, rf_wr_d, latch_d, busy_d;
    logic [3:0]         wr_addr_q, wr_addr_d, rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [3:0]         op_q, op_d, imm_q, imm_d;
    logic               use_imm_q, use_imm_d;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        wr_addr_d = wr_addr_q;
        rd_a_d    = rd_a_q;
        rd_b_d    = rd_b_q;
        op_d      = op_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;

        case (state_q)
            S_IDLE:   if (run || step) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                // Word is MSB-first: opcode, dest, srcA/imm, srcB
                state_d   = S_READ;
                op_d      = imem_data[15:12];
                wr_addr_d = imem_data[11:8];
                rd_b_d    = imem_data[3:0];
                use_imm_d = is_imm(imem_data[15:12]);
                imm_d     = is_imm(imem_data[15:12]) ? imem_data[7:4] : 4'h0;
                rd_a_d    = is_imm(imem_data[15:12]) ? 4'h0 : imem_data[7:4];
            end
            S_READ:   state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                count_d = count_q + CNT_W'(1);
                if (op_q == OP_HALT) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d    = (pc_q == PC_W'(PROG_LEN - 1)) ? '0 : pc_q + PC_W'(1);
                    state_d = run ? S_FETCH : S_IDLE;
                    if (is_illegal(op_q)) illegal_d = 1'b1;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        imem_en_d = (state_d == S_FETCH);
        rf_rd_d   = (state_d == S_READ);
        latch_d   = (state_d == S_EXEC);
        rf_wr_d   = (state_d == S_WB) && is_alu(op_d);
        busy_d    = (state_d >= S_FETCH) && (state_d <= S_WB);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            count_q     <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
            op_q        <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            imem_en     <= 1'b0;
            imem_addr   <= '0;
            rf_rd       <= 1'b0;
            rf_wr       <= 1'b0;
            alu_latch   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            wr_addr_q   <= wr_addr_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            imem_en     <= imem_en_d;
            imem_addr   <= pc_d;
            rf_rd       <= rf_rd_d;
            rf_wr       <= rf_wr_d;
            alu_latch   <= latch_d;
            busy        <= busy_d;
        end
    end

    assign state        = state_q;
    assign pc           = pc_q;
    assign instr_count  = count_q;
    assign halted       = halted_q;
    assign illegal      = illegal_q;
    assign rf_wr_addr   = wr_addr_q;
    assign rf_rd_addr_a = rd_a_q;
    assign rf_rd_addr_b = rd_b_q;
    assign alu_op       = op_q;
    assign alu_imm      = imm_q;
    assign alu_use_imm  = use_imm_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer: per-opcode vector table plus run, halt and reset sequences.
module tb_ula_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [15:0] imem_data = 16'h0;
    logic        rf_rd, rf_wr, alu_use_imm, alu_latch, busy, halted, illegal;
    logic [3:0]  rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b, alu_op, alu_imm;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic [15:0] instr_count;

    logic [15:0] mem [4];
    int          pass_cnt = 0;
    int          total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr[1:0]];

    ula_sequencer #(.PC_W(8), .PROG_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
        .rf_rd(rf_rd), .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .alu_op(alu_op), .alu_use_imm(alu_use_imm), .alu_imm(alu_imm),
        .alu_latch(alu_latch), .pc(pc), .state(state), .busy(busy),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    typedef struct {
        logic [15:0] instr;
        logic        use_imm;
        logic [3:0]  imm, rd_a, rd_b, wr_addr, op;
        logic        wr, ill, hlt;
        logic [7:0]  pc_end;
        logic [2:0]  st_end;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctrs", {pc, instr_count, 6'd0, halted, illegal}, 32'd0);
        chk("rst_strobes", {imem_en, rf_rd, alu_latch, rf_wr, busy}, 32'd0);
        chk("rst_fields", {rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, alu_op, alu_use_imm, alu_imm}, 32'd0);
    endtask

    function automatic logic [3:0] strobes();
        return {imem_en, rf_rd, alu_latch, rf_wr};
    endfunction

    initial begin
        logic seen_wr;
        mem[0] = 16'h0123; mem[1] = 16'h9157; mem[2] = 16'h2456; mem[3] = 16'h4789;

        //        instr    ui imm  a    b    wa   op   wr ill hlt pc st
        vecs[0] = '{16'h0123, 0, 4'h0, 4'h2, 4'h3, 4'h1, 4'h0, 1, 0, 0, 8'd1, 3'd0};
        vecs[1] = '{16'h9157, 1, 4'h5, 4'h0, 4'h7, 4'h1, 4'h9, 1, 0, 0, 8'd1, 3'd0};
        vecs[2] = '{16'h3A45, 1, 4'h4, 4'h0, 4'h5, 4'hA, 4'h3, 1, 0, 0, 8'd1, 3'd0};
        vecs[3] = '{16'h5CDE, 0, 4'h0, 4'hD, 4'hE, 4'hC, 4'h5, 1, 0, 0, 8'd1, 3'd0};
        vecs[4] = '{16'hB000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 0, 1, 0, 8'd1, 3'd0};
        vecs[5] = '{16'hF000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 1, 8'd0, 3'd6};

        // Single-step each vector through FETCH..WB
        foreach (vecs[i]) begin
            do_reset();
            mem[0] = vecs[i].instr;
            step = 1'b1;
            tick();
            step = 1'b0;
            chk($sformatf("v%0d_fetch", i), {state, strobes(), busy, imem_addr}, {3'd1, 4'b1000, 1'b1, 8'd0});
            tick();
            chk($sformatf("v%0d_decode", i), {state, strobes(), busy}, {3'd2, 4'b0000, 1'b1});
            tick();
            chk($sformatf("v%0d_read", i), {state, strobes()}, {3'd3, 4'b0100});
            chk($sformatf("v%0d_fields", i),
                {rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, alu_op, alu_use_imm, alu_imm},
                {vecs[i].rd_a, vecs[i].rd_b, vecs[i].wr_addr, vecs[i].op, vecs[i].use_imm, vecs[i].imm});
            tick();
            chk($sformatf("v%0d_exec", i), {state, strobes()}, {3'd4, 4'b0010});
            tick();
            chk($sformatf("v%0d_wb", i), {state, strobes(), rf_wr_addr}, {3'd5, 3'b000, vecs[i].wr, vecs[i].wr_addr});
            tick();
            chk($sformatf("v%0d_end", i), {state, pc, instr_count, illegal, halted, busy},
                {vecs[i].st_end, vecs[i].pc_end, 16'd1, vecs[i].ill, vecs[i].hlt, 1'b0});
        end

        // Free-run over a 4-word program, pc wraps 3 -> 0
        do_reset();
        mem[0] = 16'h0123; mem[1] = 16'h9157; mem[2] = 16'h2456; mem[3] = 16'h4789;
        run = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("run_fetch%0d", k), {state, imem_addr, pc}, {3'd1, 8'(k % 4), 8'(k % 4)});
            seen_wr = 1'b0;
            for (int c = 0; c < 5; c++) begin
                if (rf_wr) seen_wr = 1'b1;
                tick();
            end
            chk($sformatf("run_wr%0d", k), 32'(seen_wr), 32'd1);
        end
        chk("run_count25", {state, instr_count, pc}, {3'd1, 16'd5, 8'd1});
        // run drops mid-instruction: completes, then idles
        run = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("rundrop_wb", 32'(state), 32'd5);
        tick();
        chk("rundrop_idle", {state, instr_count, pc}, {3'd0, 16'd6, 8'd2});

        // Illegal then HALT in run mode
        do_reset();
        mem[0] = 16'h0123; mem[1] = 16'hB000; mem[2] = 16'hF000; mem[3] = 16'h0123;
        run = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) tick();
        seen_wr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (rf_wr) seen_wr = 1'b1;
            tick();
        end
        chk("ill_nowr", 32'(seen_wr), 32'd0);
        chk("ill_cont", {state, pc, illegal, halted}, {3'd1, 8'd2, 1'b1, 1'b0});
        for (int c = 0; c < 5; c++) tick();
        chk("halt_enter", {state, pc, instr_count, halted, illegal, busy}, {3'd6, 8'd2, 16'd3, 1'b1, 1'b1, 1'b0});
        for (int c = 0; c < 8; c++) begin
            step = c[0];
            tick();
        end
        step = 1'b0;
        chk("halt_stuck", {state, pc, instr_count, strobes()}, {3'd6, 8'd2, 16'd3, 4'b0000});
        do_reset();
        chk("halt_cleared", {state, halted, illegal}, {3'd0, 1'b0, 1'b0});

        // Reset during EXEC aborts the write; step during busy is ignored
        mem[0] = 16'h0123;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("abort_exec", 32'(state), 32'd4);
        rst_n = 1'b0;
        tick();
        chk("abort_rst", {state, pc, rf_wr, instr_count}, {3'd0, 8'd0, 1'b0, 16'd0});
        rst_n = 1'b1;
        seen_wr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rf_wr) seen_wr = 1'b1;
            tick();
        end
        chk("abort_nowr", {seen_wr, state, instr_count}, {1'b0, 3'd0, 16'd0});
        step = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            step = (c < 3);
            tick();
        end
        step = 1'b0;
        chk("stepign_wb", 32'(state), 32'd5);
        tick();
        tick();
        tick();
        chk("stepign_once", {state, instr_count, pc}, {3'd0, 16'd1, 8'd1});

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
- Multi-cycle control FSM that sequences the ULA datapath through fetch, decode, register read, execute and writeback.
- Drives the instruction-memory address, the RegBank read/write strobes and addresses, and the ALU operation/immediate controls.
- Sits between the board controls (run switch, debounced step key) and the ULA/RegBank pair.
- Exposes PC, FSM state and status flags for the HEX displays.

Parameters:
- PC_W, 8, program-counter width in bits.
- PROG_LEN, 256, number of instruction words; PC wraps at PROG_LEN-1. Must satisfy PROG_LEN <= 2^PC_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- run  in  1  level; 1 = free-run, instructions execute back-to-back
- step  in  1  one-cycle pulse, already debounced; executes exactly one instruction when idle
- imem_addr  out  PC_W  instruction-memory address
- imem_en  out  1  instruction-memory read enable; synchronous read, data valid the next cycle
- imem_data  in  16  instruction word [0:15]; bits 0-3 opcode, 4-7 dest, 8-11 srcA/imm, 12-15 srcB
- rf_rd  out  1  RegBank read strobe
- rf_wr  out  1  RegBank write strobe
- rf_wr_addr  out  4  RegBank write address
- rf_rd_addr_a  out  4  RegBank read address A
- rf_rd_addr_b  out  4  RegBank read address B
- alu_op  out  4  opcode presented to the ALU
- alu_use_imm  out  1  1 = ALU operand A is alu_imm
- alu_imm  out  4  immediate field
- alu_latch  out  1  ALU result-register capture enable
- pc  out  PC_W  current program counter
- state  out  3  FSM state encoding, for display
- busy  out  1  high in FETCH..WB
- halted  out  1  sticky; set by HALT
- illegal  out  1  sticky; set by an illegal opcode
- instr_count  out  16  retired-instruction counter

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - State IDLE=0; pc=0; instr_count=0; halted=0; illegal=0.
  - All strobes (imem_en, rf_rd, rf_wr, alu_latch) = 0; all address, op and imm outputs = 0.
  - Reset mid-instruction aborts it; no write occurs in that cycle.
- State encodings: IDLE=0, FETCH=1, DECODE=2, READ=3, EXEC=4, WB=5, HALT=6.
- IDLE: enter FETCH if run=1 or step=1. step is ignored in every state other than IDLE.
- FETCH, 1 cycle: imem_en=1, imem_addr=pc. Next state DECODE.
- DECODE, 1 cycle: IR <= imem_data. Next state READ.
- Decoded fields are held stable from READ through WB: rf_wr_addr=IR[4:7], rf_rd_addr_b=IR[12:15], alu_op=IR[0:3].
- Immediate-type opcodes: 0011 SLTI, 0110 ANDI, 0111 ORI, 1000 XORI, 1001 ADDI, 1010 SUBI.
  - For these: alu_use_imm=1, alu_imm=IR[8:11], rf_rd_addr_a=0.
  - For all other opcodes: alu_use_imm=0, alu_imm=0, rf_rd_addr_a=IR[8:11].
- Register-type opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0100 OR, 0101 XOR.
- Special opcodes:
  - 1111 = HALT.
  - 1011-1110 = illegal: treated as NOP and set illegal.
- READ, 1 cycle: rf_rd=1. Next state EXEC.
- EXEC, 1 cycle: alu_latch=1. Next state WB.
- WB, 1 cycle:
  - rf_wr=1 only for the 11 legal ALU opcodes.
  - pc <= (pc==PROG_LEN-1) ? 0 : pc+1.
  - instr_count++ for every retired instruction; wraps at 16'hFFFF to 0.
  - Next state FETCH if run=1, else IDLE.
- HALT opcode in WB:
  - No write, pc unchanged, instr_count++, halted=1.
  - Next state HALT; HALT is exited only by reset.
- Illegal opcode in WB: no write, pc advances, illegal=1 (sticky until reset), execution continues.
- Latency: 5 cycles per instruction from FETCH to WB inclusive. In run mode the next FETCH follows WB directly.
- Strobes: exactly one of imem_en, rf_rd, alu_latch, rf_wr is high per busy cycle; none is high in IDLE or HALT.
- run falling mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE.
- step and run both high in IDLE: FETCH; run governs the WB decision.
- busy = state in {FETCH, DECODE, READ, EXEC, WB}.

Test Plan:
- Reset, then a single step pulse with imem[0]=16'h0123 (ADD r1=r2+r3) -> FETCH..WB over 5 cycles; rf_rd_addr_a=2, rf_rd_addr_b=3, rf_wr=1 with rf_wr_addr=1 in cycle 5; pc=1; instr_count=1; back in IDLE.
- imem[0]=16'h9157 (ADDI) -> alu_use_imm=1, alu_imm=5, rf_rd_addr_b=7, rf_wr_addr=1, rf_rd_addr_a=0.
- run=1, PROG_LEN=4, all NOPs replaced by legal ops -> pc sequence 0,1,2,3,0; a new FETCH every 5 cycles; instr_count=5 after 25 cycles.
- imem[1]=16'hB000 (illegal) -> no rf_wr in its WB, illegal=1 stays set, pc advances to 2, execution continues.
- imem[2]=16'hF000 (HALT) in run mode -> halted=1, state=6, pc stays 2, further step and run have no effect until rst_n=0.
- Reset asserted during EXEC -> the next cycle shows state=0, pc=0, rf_wr never pulses; step pulses during busy cycles are ignored (instr_count increments only once).
